// File: rtl/top_reg_bank.sv
// 14 x 16-bit register bank with a single write port and a registered read port.
// Reads are read-before-write; out-of-range addresses write nothing and read zero.
module top_reg_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  addr_valid_s;

  assign addr_valid_s = (addr < ADDR_WIDTH'(NUM_REGS));

  // Read mux and next-state for storage and the output register.
  always_comb begin
    rd_data_s  = {DATA_WIDTH{1'b0}};
    data_out_d = data_out_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (addr == ADDR_WIDTH'(i)) begin
        rd_data_s = regs_q[i];
        if (write_en) begin
          regs_d[i] = data_in;
        end else begin
          regs_d[i] = regs_q[i];
        end
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
    if (read_en) begin
      data_out_d = addr_valid_s ? rd_data_s : {DATA_WIDTH{1'b0}};
    end else begin
      data_out_d = data_out_q;
    end
  end

  // State registers; reset clears everything and masks any write in that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
      data_out_q <= {DATA_WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_top_reg_bank.sv
// Directed plus random bench for top_reg_bank, checked against an array model.
module tb_top_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en;
  logic        read_en;
  logic [3:0]  addr;
  logic [15:0] data_in;
  logic [15:0] data_out;

  logic [15:0] model [14];
  logic [15:0] exp_out;
  int errors = 0;
  int checks = 0;

  top_reg_bank dut (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
    .addr(addr), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag);
    checks++;
    assert (data_out === exp_out) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, data_out, exp_out);
    end
  endtask

  task automatic step(input logic we, input logic re, input logic [3:0] a,
                      input logic [15:0] d, input string tag);
    rst = 1'b0; write_en = we; read_en = re; addr = a; data_in = d;
    @(posedge clk);
    if (re) exp_out = (a < 4'd14) ? model[a] : 16'h0000;
    if (we && a < 4'd14) model[a] = d;
    #1;
    check(tag);
  endtask

  task automatic do_reset(input int n, input logic we, input logic [3:0] a,
                          input logic [15:0] d);
    for (int k = 0; k < n; k++) begin
      rst = 1'b1; write_en = we; read_en = 1'b1; addr = a; data_in = d;
      @(posedge clk);
      for (int r = 0; r < 14; r++) model[r] = 16'h0000;
      exp_out = 16'h0000;
      #1;
      check("reset");
    end
    rst = 1'b0; write_en = 1'b0; read_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; write_en = 1'b0; read_en = 1'b0; addr = 4'd0; data_in = 16'h0000;
    exp_out = 16'h0000;
    for (int r = 0; r < 14; r++) model[r] = 16'hxxxx;

    do_reset(2, 1'b0, 4'd0, 16'h0000);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 4'(i), 16'h0000, "reset_read");

    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b0, 4'(i), 16'h1234 + 16'(i), "write_hold");
      step(1'b0, 1'b1, 4'(i), 16'h0000, "basic_read");
    end
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 4'(i), 16'h0000, "retain");

    step(1'b1, 1'b0, 4'd14, 16'hDEAD, "illegal_wr14");
    step(1'b1, 1'b0, 4'd15, 16'hDEAD, "illegal_wr15");
    step(1'b0, 1'b1, 4'd14, 16'h0000, "illegal_rd14");
    step(1'b0, 1'b1, 4'd15, 16'h0000, "illegal_rd15");
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 4'(i), 16'h0000, "illegal_untouched");

    step(1'b1, 1'b0, 4'd5, 16'h1111, "rbw_setup");
    step(1'b1, 1'b1, 4'd5, 16'h2222, "rbw_old");
    step(1'b0, 1'b1, 4'd5, 16'h0000, "rbw_new");

    step(1'b1, 1'b0, 4'd7, 16'hABCD, "hold_setup");
    step(1'b0, 1'b1, 4'd7, 16'h0000, "hold_read");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'(k), 16'hFFFF, "hold_idle");
    step(1'b1, 1'b0, 4'd3, 16'h5555, "pre_reset_write");
    step(1'b0, 1'b1, 4'd3, 16'h0000, "pre_reset_read");
    do_reset(1, 1'b1, 4'd3, 16'h5555);
    step(1'b0, 1'b1, 4'd3, 16'h0000, "post_reset_reg3");

    for (int t = 0; t < 100; t++) begin
      step(1'($urandom), 1'($urandom), 4'($urandom_range(0, 13)),
           16'($urandom), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
